// File: rtl/tc_clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tc_clk_gate_ctrl
// Per-domain clock-gate sequencer. It drives the enable pins of NumDomains ICG
// cells from the ungated root clock. A domain that stays idle for IdleCycles
// consecutive cycles has its clock gated. Activity or a wake request reopens
// the clock. A wake request is acknowledged only after WakeCycles settle
// cycles, once the gated clock is known to be running and stable.
//
// Optional feature macro: CLK_GATE_CTRL_STATS_EN
//   When defined, a saturating 32-bit gated-cycle counter is built per domain.
//   When undefined, gated_cnt_o is tied to zero and stats_clr_i is ignored.
//
// Ports
//   clk_i        in   root (ungated) clock
//   rst_i        in   asynchronous active-high reset
//   test_en_i    in   scan/test override, forces every clock on
//   busy_i       in   per-domain activity level
//   wake_req_i   in   per-domain wake request, held until wake_ack_o
//   wake_ack_o   out  per-domain clock running and stable (RUN or DRAIN)
//   clk_en_o     out  per-domain enable to the ICG en_i pin
//   gated_o      out  per-domain status, domain is in GATED
//   stats_clr_i  in   synchronous clear of the gated-cycle counters
//   gated_cnt_o  out  per-domain gated-cycle count, domain d at [32d+:32]
// -----------------------------------------------------------------------------
module tc_clk_gate_ctrl #(
  parameter int NumDomains = 4,
  parameter int IdleCycles = 16,
  parameter int WakeCycles = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    test_en_i,
  input  logic [NumDomains-1:0]   busy_i,
  input  logic [NumDomains-1:0]   wake_req_i,
  output logic [NumDomains-1:0]   wake_ack_o,
  output logic [NumDomains-1:0]   clk_en_o,
  output logic [NumDomains-1:0]   gated_o,
  input  logic                    stats_clr_i,
  output logic [32*NumDomains-1:0] gated_cnt_o
);

  // One counter per domain serves both the drain and the wake phase, so it is
  // sized for the longer of the two.
  localparam int MaxCycles = (IdleCycles > WakeCycles) ? IdleCycles : WakeCycles;
  localparam int CntWidth  = $clog2(MaxCycles + 1);

  localparam logic [CntWidth-1:0] CntZero   = {CntWidth{1'b0}};
  localparam logic [CntWidth-1:0] CntOne    = {{(CntWidth-1){1'b0}}, 1'b1};
  localparam logic [CntWidth-1:0] IdleLast  = CntWidth'(IdleCycles - 1);
  localparam logic [CntWidth-1:0] WakeLast  = CntWidth'(WakeCycles - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } state_e;

  // Elaboration-time parameter sanity.
  if (NumDomains < 1) begin : g_bad_num_domains
    $error("tc_clk_gate_ctrl: NumDomains must be >= 1");
  end
  if (IdleCycles < 1) begin : g_bad_idle_cycles
    $error("tc_clk_gate_ctrl: IdleCycles must be >= 1");
  end
  if (WakeCycles < 1) begin : g_bad_wake_cycles
    $error("tc_clk_gate_ctrl: WakeCycles must be >= 1");
  end

  // A domain is idle only when it is neither busy nor asking to wake.
  logic [NumDomains-1:0] idle_s;
  assign idle_s = ~busy_i & ~wake_req_i;

  // Registered per-domain decodes, collected from the generate blocks.
  logic [NumDomains-1:0] clk_en_vec_s;
  logic [NumDomains-1:0] wake_ack_vec_s;
  logic [NumDomains-1:0] gated_vec_s;

  // test_en_i is the only combinational path to the outputs. This lets scan
  // force every clock on in the same cycle it is asserted.
  assign clk_en_o   = clk_en_vec_s   | {NumDomains{test_en_i}};
  assign wake_ack_o = wake_ack_vec_s | {NumDomains{test_en_i}};
  assign gated_o    = gated_vec_s;

  for (genvar d = 0; d < NumDomains; d++) begin : g_dom
    state_e              state_r;
    logic [CntWidth-1:0] cnt_r;
    logic                clk_en_r;
    logic                wake_ack_r;
    logic                gated_r;

    // Per-domain gating FSM. Outputs are decoded from the current state one
    // cycle later. As a result, clk_en_o falls IdleCycles+1 cycles after the
    // first idle sample, and rises one cycle after a wake is sampled.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_r    <= ST_RUN;
        cnt_r      <= CntZero;
        clk_en_r   <= 1'b1;
        wake_ack_r <= 1'b1;
        gated_r    <= 1'b0;
      end else begin
        clk_en_r   <= (state_r != ST_GATED);
        wake_ack_r <= (state_r == ST_RUN) || (state_r == ST_DRAIN);
        gated_r    <= (state_r == ST_GATED);

        if (test_en_i) begin
          state_r <= ST_RUN;
          cnt_r   <= CntZero;
        end else begin
          case (state_r)
            ST_RUN: begin
              if (idle_s[d]) begin
                state_r <= ST_DRAIN;
                cnt_r   <= CntZero;
              end else begin
                state_r <= ST_RUN;
                cnt_r   <= cnt_r;
              end
            end
            ST_DRAIN: begin
              // Activity takes priority over the terminal count, so a
              // late wake never races the gate closing.
              if (!idle_s[d]) begin
                state_r <= ST_RUN;
                cnt_r   <= CntZero;
              end else if (cnt_r == IdleLast) begin
                state_r <= ST_GATED;
                cnt_r   <= CntZero;
              end else begin
                state_r <= ST_DRAIN;
                cnt_r   <= cnt_r + CntOne;
              end
            end
            ST_GATED: begin
              if (!idle_s[d]) begin
                state_r <= ST_WAKE;
                cnt_r   <= CntZero;
              end else begin
                state_r <= ST_GATED;
                cnt_r   <= cnt_r;
              end
            end
            ST_WAKE: begin
              // The settle period always runs to completion, even if the
              // request is withdrawn. Any re-gating goes through DRAIN again.
              if (cnt_r == WakeLast) begin
                state_r <= ST_RUN;
                cnt_r   <= CntZero;
              end else begin
                state_r <= ST_WAKE;
                cnt_r   <= cnt_r + CntOne;
              end
            end
            default: begin
              state_r <= ST_RUN;
              cnt_r   <= CntZero;
            end
          endcase
        end
      end
    end

    assign clk_en_vec_s[d]   = clk_en_r;
    assign wake_ack_vec_s[d] = wake_ack_r;
    assign gated_vec_s[d]    = gated_r;

`ifdef CLK_GATE_CTRL_STATS_EN
    logic [31:0] gated_cnt_r;

    // Saturating gated-cycle counter. A clear takes priority over an increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        gated_cnt_r <= 32'd0;
      end else if (stats_clr_i) begin
        gated_cnt_r <= 32'd0;
      end else if (gated_r && (gated_cnt_r != 32'hFFFF_FFFF)) begin
        gated_cnt_r <= gated_cnt_r + 32'd1;
      end else begin
        gated_cnt_r <= gated_cnt_r;
      end
    end

    assign gated_cnt_o[32*d +: 32] = gated_cnt_r;
`else
    assign gated_cnt_o[32*d +: 32] = 32'd0;
`endif
  end

`ifndef CLK_GATE_CTRL_STATS_EN
  // The stats clear has no function when the counters are not built.
  logic unused_stats_clr_s;
  assign unused_stats_clr_s = stats_clr_i;
`endif

endmodule

// File: tb/tb_tc_clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tc_clk_gate_ctrl
// Directed testbench for tc_clk_gate_ctrl with its default parameters
// (4 domains, IdleCycles=16, WakeCycles=2). Inputs change on the falling edge.
// Outputs are sampled on the falling edge, or 1 time unit after an input
// change when a combinational path is being checked. The stats checks follow
// CLK_GATE_CTRL_STATS_EN.
// -----------------------------------------------------------------------------
module tb_tc_clk_gate_ctrl;

  logic         clk;
  logic         rst;
  logic         test_en;
  logic [3:0]   busy;
  logic [3:0]   wake_req;
  logic [3:0]   wake_ack;
  logic [3:0]   clk_en;
  logic [3:0]   gated;
  logic         stats_clr;
  logic [127:0] gated_cnt;

  int total_cnt = 0;
  int pass_cnt  = 0;

  tc_clk_gate_ctrl #(
    .NumDomains (4),
    .IdleCycles (16),
    .WakeCycles (2)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .test_en_i   (test_en),
    .busy_i      (busy),
    .wake_req_i  (wake_req),
    .wake_ack_o  (wake_ack),
    .clk_en_o    (clk_en),
    .gated_o     (gated),
    .stats_clr_i (stats_clr),
    .gated_cnt_o (gated_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Let n rising edges pass, then stop at the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic dropped;
    rst       = 1'b1;
    test_en   = 1'b0;
    busy      = 4'hF;
    wake_req  = 4'h0;
    stats_clr = 1'b0;

    // Reset values
    step(2);
    check("rst_clk_en", clk_en, 4'hF);
    check("rst_ack", wake_ack, 4'hF);
    check("rst_gated", gated, 4'h0);
    check("rst_cnt", gated_cnt, 128'd0);
    rst = 1'b0;
    step(1);
    check("run_clk_en", clk_en, 4'hF);

    // Domain 0 idle: enable falls exactly 17 cycles after the first idle sample.
    busy = 4'b1110;
    step(17);
    check("a_en_pre", clk_en, 4'hF);
    check("a_ack_drain", wake_ack, 4'hF);
    step(1);
    check("a_en_gated", clk_en, 4'b1110);
    check("a_gated", gated, 4'b0001);
    check("a_ack_gated", wake_ack, 4'b1110);

    // Domain 1: a busy pulse at DRAIN cnt=10 restarts the full 17-cycle drain.
    busy = 4'b1100;
    step(11);
    busy = 4'b1110;
    step(1);
    busy = 4'b1100;
    dropped = 1'b0;
    for (int i = 0; i < 17; i++) begin
      step(1);
      if (!clk_en[1]) dropped = 1'b1;
    end
    check("b_never_drop", dropped, 1'b0);
    step(1);
    check("b_en_gated", clk_en[1], 1'b0);

    // Domain 2: gate, then wake with the request.
    busy = 4'b1000;
    step(18);
    check("c_gated", gated, 4'b0111);
    wake_req = 4'b0100;
    step(1);
    check("c_en_t0", clk_en[2], 1'b0);
    step(1);
    check("c_en_t1", clk_en[2], 1'b1);
    check("c_ack_t1", wake_ack[2], 1'b0);
    step(1);
    check("c_ack_t2", wake_ack[2], 1'b0);
    step(1);
    check("c_ack_t3", wake_ack[2], 1'b1);
    check("c_gated_t3", gated[2], 1'b0);
    wake_req = 4'b0000;

    // Domain 3: activity on the terminal DRAIN cycle wins, so there is no gating.
    busy = 4'b0000;
    step(16);
    busy = 4'b1000;
    step(1);
    check("d_en_t16", clk_en[3], 1'b1);
    step(1);
    check("d_en_t17", clk_en[3], 1'b1);
    step(1);
    check("d_gated", gated[3], 1'b0);

    // All domains idle, so all become gated.
    busy = 4'b0000;
    step(20);
    check("all_gated", gated, 4'hF);
    check("all_en_low", clk_en, 4'h0);

    // Domain 0: the request drops during WAKE. WAKE still completes, then re-gates.
    wake_req = 4'b0001;
    step(1);
    wake_req = 4'b0000;
    step(1);
    check("e_en_up", clk_en[0], 1'b1);
    step(1);
    check("e_ack_wake", wake_ack[0], 1'b0);
    step(1);
    check("e_ack_run", wake_ack[0], 1'b1);
    step(16);
    check("e_en_pre", clk_en[0], 1'b1);
    step(1);
    check("e_en_regated", clk_en[0], 1'b0);
    check("e_all_gated", gated, 4'hF);

    // The test override forces the outputs high in the same cycle, and the FSMs to RUN.
    test_en = 1'b1;
    #1;
    check("t_en_same", clk_en, 4'hF);
    check("t_ack_same", wake_ack, 4'hF);
    step(2);
    check("t_gated_clr", gated, 4'h0);
    test_en = 1'b0;
    #1;
    check("t_en_after", clk_en, 4'hF);
    check("t_ack_after", wake_ack, 4'hF);
    step(18);
    check("t_regated", clk_en, 4'h0);

    // Stats counters
    stats_clr = 1'b1;
    step(1);
    stats_clr = 1'b0;
    step(100);
`ifdef CLK_GATE_CTRL_STATS_EN
    check("s_cnt3_100", gated_cnt[96 +: 32], 32'd100);
`else
    check("s_cnt3_off", gated_cnt[96 +: 32], 32'd0);
`endif
    stats_clr = 1'b1;
    step(1);
    stats_clr = 1'b0;
    check("s_cnt3_clr", gated_cnt[96 +: 32], 32'd0);

    // Reset asserted in the middle of a WAKE
    wake_req = 4'b1000;
    step(2);
    check("r_en_wake", clk_en[3], 1'b1);
    check("r_ack_wake", wake_ack[3], 1'b0);
    rst = 1'b1;
    #1;
    check("r_en", clk_en, 4'hF);
    check("r_ack", wake_ack, 4'hF);
    check("r_gated", gated, 4'h0);
    check("r_cnt", gated_cnt, 128'd0);
    step(2);
    rst      = 1'b0;
    wake_req = 4'b0000;
    busy     = 4'hF;
    step(1);
    check("r_release", clk_en, 4'hF);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
